fpaddsub_arbiter: RTL and testbench
===================================

# fpaddsub_arbiter

Sequencing controller and two-port round-robin arbiter that shares one combinational floating-point add/sub datapath between two requesters. The datapath uses an 11-bit mantissa with the hidden bit at [10], a sign bit, a 5-bit input exponent and a 6-bit result exponent. The arbiter accepts one operation at a time from either port and registers the operands that drive the datapath. It waits a fixed settle time, captures the datapath result and returns it to the winning requester over a valid/ready handshake. It sits between the datapath and its clients.

## Interface
- EXEC_CYCLES, 2, settle cycles allowed for the datapath after operands are registered; legal range 1..15.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  operation offered.
- req0_ready / req1_ready  out  1  operation accepted this cycle.
- req0_data / req1_data  in  35  packed operation {op, sgn1, exp1[4:0], man1[10:0], sgn2, exp2[4:0], man2[10:0]}.
  - op=0: add; op=1: subtract.
- resp0_valid / resp1_valid  out  1  result available.
- resp0_ready / resp1_ready  in  1  requester takes result.
- resp_data  out  18  {sgn, exp[5:0], man[10:0]}; shared by both ports; meaningful only with a respN_valid.
- dp_op, dp_sgn1, dp_exp1[4:0], dp_man1[10:0], dp_sgn2, dp_exp2[4:0], dp_man2[10:0]  out  —  registered datapath operands.
- dp_sgnout, dp_outexp[5:0], dp_out[10:0]  in  —  datapath result.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  port owning the current or last operation.

## Operation
- FSM states and transitions:
  - IDLE → EXEC on acceptance.
  - EXEC → RESP after EXEC_CYCLES cycles.
  - RESP → IDLE on handshake with the granted port.
- IDLE:
  - The winner's reqN_ready is driven combinationally high while its reqN_valid is high. The loser's ready stays 0.
  - On acceptance, the winner's req data is loaded into the dp_* registers, grant_id is set and the counter loads EXEC_CYCLES-1.
- Arbitration:
  - A lone valid wins.
  - When both ports are valid, the port not named by last_grant wins; last_grant updates on acceptance.
  - last_grant resets to 1, so req0 wins the first contention.
- EXEC: the counter decrements each cycle. When it reaches 0, {dp_sgnout, dp_outexp, dp_out} is captured into resp_data and the FSM moves to RESP.
- RESP:
  - resp<grant_id>_valid is held high; the other resp valid is 0.
  - resp_data is held stable until respN_ready.
  - New requests are not accepted; both req ready signals are 0.
- The dp_* registers hold their value from acceptance until the next acceptance.
- The arbiter performs no arithmetic on operands or results; widths pass through unchanged.

## Timing
- Reset values: FSM=IDLE, all reqN_ready=0 while rst is high, respN_valid=0, resp_data=0, dp_* registers=0, busy=0, grant_id=0, last_grant=1.
- Acceptance in cycle t:
  - busy is high at t+1.
  - respN_valid is high at t+EXEC_CYCLES+1.
  - If respN_ready is high in that same cycle, the FSM is in IDLE at t+EXEC_CYCLES+2.
- Back-to-back throughput is one operation per EXEC_CYCLES+2 cycles.
- respN_ready asserted early, while not in RESP, is ignored.
- A requester dropping valid before ready is legal; no request is taken.
- Reset during EXEC or RESP aborts the operation: no response is produced and the next cycle is in IDLE.
- A requester's valid seen during RESP stays pending. It is arbitrated in the first IDLE cycle, with the updated last_grant.

## Configuration
- FPARB_FIXED_PRIO_EN:
  - Defined: fixed priority. req0 always wins contention and last_grant is unused (held at reset value).
  - Undefined (default): round-robin as described above.

## Test plan
- Single op, EXEC_CYCLES=2:
  - Stimulus: req0 add, (0, 5'd3, 11'h400) + (0, 5'd3, 11'h400).
  - Response: req0_ready in cycle t; resp0_valid at t+3; resp_data = {0, 6'd4, 11'h400}.
- Contention: req0 and req1 both valid from reset.
  - Response: req0 is granted first, req1 second, then req0 again.
  - With FPARB_FIXED_PRIO_EN defined: req0 is granted every time.
- Response backpressure: resp1_ready held low for 5 cycles.
  - Response: resp1_valid and resp_data are stable throughout; both req ready signals are 0; busy=1.
- Subtract:
  - Stimulus: req1 op=1, (0, 5'd4, 11'h600) − (0, 5'd3, 11'h400).
  - Response: resp_data = {0, 6'd4, 11'h400}; resp0_valid stays 0.
- Reset mid-EXEC: rst pulsed in the second EXEC cycle.
  - Response: no respN_valid; busy=0 the next cycle; a following req0 completes normally.
- EXEC_CYCLES=15:
  - Response: valid appears exactly 16 cycles after acceptance; no wrap of the counter.

Source files
------------

// File: rtl/fpaddsub_arbiter.sv
// Two-port arbiter sequencing one shared combinational FP add/sub datapath.
// Define FPARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module fpaddsub_arbiter #(
    parameter int EXEC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [34:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [34:0] req1_data,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [17:0] resp_data,
    output logic        dp_op,
    output logic        dp_sgn1,
    output logic [4:0]  dp_exp1,
    output logic [10:0] dp_man1,
    output logic        dp_sgn2,
    output logic [4:0]  dp_exp2,
    output logic [10:0] dp_man2,
    input  logic        dp_sgnout,
    input  logic [5:0]  dp_outexp,
    input  logic [10:0] dp_out,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        last_grant;
    logic        winner;
    logic        accept;
    logic        capture;
    logic [34:0] win_data;

    // winner: 0 selects req0, 1 selects req1
    always_comb begin
`ifdef FPARB_FIXED_PRIO_EN
        winner = ~req0_valid;
`else
        winner = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
`endif
    end

    assign win_data = winner ? req1_data : req0_data;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        accept      = 1'b0;
        capture     = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~winner;
                    req1_ready = winner;
                    cnt_nxt    = CNT_LOAD;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                resp0_valid = ~grant_id;
                resp1_valid = grant_id;
                if (grant_id ? resp1_ready : resp0_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Operands stay registered from acceptance until the next acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_op      <= 1'b0;
            dp_sgn1    <= 1'b0;
            dp_exp1    <= 5'd0;
            dp_man1    <= 11'd0;
            dp_sgn2    <= 1'b0;
            dp_exp2    <= 5'd0;
            dp_man2    <= 11'd0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            resp_data  <= 18'd0;
        end else begin
            if (accept) begin
                {dp_op, dp_sgn1, dp_exp1, dp_man1, dp_sgn2, dp_exp2, dp_man2} <= win_data;
                grant_id <= winner;
`ifndef FPARB_FIXED_PRIO_EN
                last_grant <= winner;
`endif
            end
            if (capture) begin
                resp_data <= {dp_sgnout, dp_outexp, dp_out};
            end
        end
    end

endmodule

// File: tb/tb_fpaddsub_arbiter.sv
// Self-checking bench for fpaddsub_arbiter: a bench-side FP datapath feeds the DUT and
// a time-based transaction model is compared against the DUT every cycle.
module tb_fpaddsub_arbiter;

    localparam int E = 2;

    localparam logic [34:0] ADD33 = {1'b0, 1'b0, 5'd3, 11'h400, 1'b0, 5'd3, 11'h400};
    localparam logic [34:0] SUB43 = {1'b1, 1'b0, 5'd4, 11'h600, 1'b0, 5'd3, 11'h400};
    localparam logic [34:0] ADD53 = {1'b0, 1'b0, 5'd5, 11'h400, 1'b0, 5'd3, 11'h400};
    localparam logic [17:0] R4    = {1'b0, 6'd4, 11'h400};
    localparam logic [17:0] R5    = {1'b0, 6'd5, 11'h500};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [34:0] req0_data, req1_data;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [17:0] resp_data;
    logic        dp_op, dp_sgn1, dp_sgn2, dp_sgnout, busy, grant_id;
    logic [4:0]  dp_exp1, dp_exp2;
    logic [10:0] dp_man1, dp_man2, dp_out;
    logic [5:0]  dp_outexp;

    logic        rst15, v15, rdy15, rv15, busy15, gid15, nc_rdy1, nc_rv1;
    logic [34:0] data15;
    logic [17:0] rd15;
    logic        d15_op, d15_s1, d15_s2, d15_so;
    logic [4:0]  d15_e1, d15_e2;
    logic [10:0] d15_m1, d15_m2, d15_mo;
    logic [5:0]  d15_eo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference add/sub: align the smaller magnitude, add or subtract, renormalise.
    function automatic logic [17:0] fp_ref(input logic [34:0] d);
        logic sa, sb;
        int   ea, eb, ma, mb, r, e;
        if ({d[32:28], d[27:17]} >= {d[15:11], d[10:0]}) begin
            sa = d[33];         ea = int'(d[32:28]); ma = int'(d[27:17]);
            sb = d[16] ^ d[34]; eb = int'(d[15:11]); mb = int'(d[10:0]);
        end else begin
            sa = d[16] ^ d[34]; ea = int'(d[15:11]); ma = int'(d[10:0]);
            sb = d[33];         eb = int'(d[32:28]); mb = int'(d[27:17]);
        end
        mb = (ea - eb > 11) ? 0 : (mb >> (ea - eb));
        e = ea;
        if (sa == sb) begin
            r = ma + mb;
            if (r >= 2048) begin
                r = r >> 1;
                e = e + 1;
            end
        end else begin
            r = ma - mb;
            if (r == 0) return 18'd0;
            for (int k = 0; k < 11 && r < 1024; k++) begin
                r = r << 1;
                e = e - 1;
            end
        end
        return {sa, 6'(e), 11'(r)};
    endfunction

    function automatic logic [34:0] rnd_op();
        return {1'($urandom), 1'($urandom), 5'($urandom), 1'b1, 10'($urandom),
                1'($urandom), 5'($urandom), 1'b1, 10'($urandom)};
    endfunction

    always_comb {dp_sgnout, dp_outexp, dp_out} =
        fp_ref({dp_op, dp_sgn1, dp_exp1, dp_man1, dp_sgn2, dp_exp2, dp_man2});
    always_comb {d15_so, d15_eo, d15_mo} =
        fp_ref({d15_op, d15_s1, d15_e1, d15_m1, d15_s2, d15_e2, d15_m2});

    fpaddsub_arbiter #(.EXEC_CYCLES(E)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data),
        .dp_op(dp_op), .dp_sgn1(dp_sgn1), .dp_exp1(dp_exp1), .dp_man1(dp_man1),
        .dp_sgn2(dp_sgn2), .dp_exp2(dp_exp2), .dp_man2(dp_man2),
        .dp_sgnout(dp_sgnout), .dp_outexp(dp_outexp), .dp_out(dp_out),
        .busy(busy), .grant_id(grant_id)
    );

    fpaddsub_arbiter #(.EXEC_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst15),
        .req0_valid(v15), .req0_ready(rdy15), .req0_data(data15),
        .req1_valid(1'b0), .req1_ready(nc_rdy1), .req1_data(35'd0),
        .resp0_valid(rv15), .resp0_ready(1'b1),
        .resp1_valid(nc_rv1), .resp1_ready(1'b1),
        .resp_data(rd15),
        .dp_op(d15_op), .dp_sgn1(d15_s1), .dp_exp1(d15_e1), .dp_man1(d15_m1),
        .dp_sgn2(d15_s2), .dp_exp2(d15_e2), .dp_man2(d15_m2),
        .dp_sgnout(d15_so), .dp_outexp(d15_eo), .dp_out(d15_mo),
        .busy(busy15), .grant_id(gid15)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: one outstanding op, response due E+1 cycles after acceptance.
    bit          m_ok = 1'b0;
    bit          m_active, m_port, m_lg, m_grant;
    int          m_acc;
    logic [34:0] m_data, m_dp;

    always @(negedge clk) begin
        bit due, w, e0, e1;
        due = m_ok && m_active && (cyc >= m_acc + E + 1);
        if (m_ok) begin
            chk("busy", 64'(busy), 64'(m_active));
            chk("resp0_valid", 64'(resp0_valid), 64'(due && !m_port));
            chk("resp1_valid", 64'(resp1_valid), 64'(due && m_port));
            if (due) chk("resp_data", 64'(resp_data), 64'(fp_ref(m_data)));
            chk("grant_id", 64'(grant_id), 64'(m_grant));
            chk("dp_operands", 64'({dp_op, dp_sgn1, dp_exp1, dp_man1, dp_sgn2, dp_exp2, dp_man2}),
                64'(m_dp));
        end
`ifdef FPARB_FIXED_PRIO_EN
        w = !req0_valid;
`else
        w = (req0_valid && req1_valid) ? !m_lg : !req0_valid;
`endif
        e0 = !rst && m_ok && !m_active && req0_valid && !w;
        e1 = !rst && m_ok && !m_active && req1_valid && w;
        if (m_ok || rst) begin
            chk("req0_ready", 64'(req0_ready), 64'(e0));
            chk("req1_ready", 64'(req1_ready), 64'(e1));
        end
        if (rst) begin
            m_ok = 1'b1; m_active = 1'b0; m_lg = 1'b1; m_grant = 1'b0; m_dp = '0;
        end else if (m_ok) begin
            if (m_active) begin
                if (due && (m_port ? resp1_ready : resp0_ready)) m_active = 1'b0;
            end else if (req0_valid || req1_valid) begin
                m_active = 1'b1;
                m_port   = w;
                m_acc    = cyc;
                m_data   = w ? req1_data : req0_data;
                m_dp     = m_data;
                m_grant  = w;
`ifndef FPARB_FIXED_PRIO_EN
                m_lg     = w;
`endif
            end
        end
    end

    task automatic send(input bit p, input logic [34:0] d, output int t);
        t = -1;
        if (p) begin req1_data = d; req1_valid = 1'b1; end
        else   begin req0_data = d; req0_valid = 1'b1; end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) begin
                t = cyc;
                break;
            end
        end
        chk("send_accepted", 64'(t >= 0), 64'd1);
        @(posedge clk); #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rv(input bit p, output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p ? resp1_valid : resp0_valid) begin
                c = cyc;
                break;
            end
        end
        chk("resp_seen", 64'(c >= 0), 64'd1);
    endtask

    task automatic wait_idle();
        int seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1;
                break;
            end
        end
        chk("return_to_idle", 64'(seen), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, g;
        int order[3];
        logic [17:0] snap;

        rst = 1'b1; rst15 = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        v15 = 1'b0; data15 = '0;

        chk("fp_model_add", 64'(fp_ref(ADD33)), 64'(R4));
        chk("fp_model_sub", 64'(fp_ref(SUB43)), 64'(R4));
        chk("fp_model_align", 64'(fp_ref(ADD53)), 64'(R5));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_resp_data", 64'(resp_data), 64'd0);
        chk("reset_grant_id", 64'(grant_id), 64'd0);
        chk("reset_dp_man1", 64'(dp_man1), 64'd0);
        @(posedge clk); #1;

        // single add on req0
        send(1'b0, ADD33, t);
        wait_rv(1'b0, c);
        chk("single_latency", 64'(c - t), 64'(E + 1));
        chk("single_data", 64'(resp_data), 64'(R4));
        wait_idle();

        // contention from reset
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = ADD33; req1_data = ADD53;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            g = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    g = int'(req1_ready);
                    break;
                end
            end
            order[k] = g;
            @(posedge clk); #1;
            if (g == 1) req1_data = rnd_op(); else req0_data = rnd_op();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef FPARB_FIXED_PRIO_EN
        chk("contention_grant0", 64'(order[0]), 64'd0);
        chk("contention_grant1", 64'(order[1]), 64'd0);
        chk("contention_grant2", 64'(order[2]), 64'd0);
`else
        chk("contention_grant0", 64'(order[0]), 64'd0);
        chk("contention_grant1", 64'(order[1]), 64'd1);
        chk("contention_grant2", 64'(order[2]), 64'd0);
`endif
        wait_idle();

        // subtract on req1 with response backpressure and req0 pending
        resp1_ready = 1'b0;
        send(1'b1, SUB43, t);
        req0_data = ADD53; req0_valid = 1'b1;
        wait_rv(1'b1, c);
        chk("sub_latency", 64'(c - t), 64'(E + 1));
        chk("sub_data", 64'(resp_data), 64'(R4));
        snap = resp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp1_valid", 64'(resp1_valid), 64'd1);
            chk("bp_resp0_valid", 64'(resp0_valid), 64'd0);
            chk("bp_resp_data", 64'(resp_data), 64'(snap));
            chk("bp_req0_ready", 64'(req0_ready), 64'd0);
            chk("bp_req1_ready", 64'(req1_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #1 resp1_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pending_req0_ready", 64'(req0_ready), 64'd1);
        @(posedge clk); #1 req0_valid = 1'b0;
        wait_idle();

        // reset in the second EXEC cycle
        send(1'b0, ADD33, t);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_resp", 64'(resp0_valid | resp1_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(1'b0, ADD53, t);
        wait_rv(1'b0, c);
        chk("after_abort_latency", 64'(c - t), 64'(E + 1));
        chk("after_abort_data", 64'(resp_data), 64'(R5));
        wait_idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            req0_valid  = ($urandom_range(0, 99) < 50);
            req1_valid  = ($urandom_range(0, 99) < 50);
            req0_data   = rnd_op();
            req1_data   = rnd_op();
            resp0_ready = ($urandom_range(0, 99) < 70);
            resp1_ready = ($urandom_range(0, 99) < 70);
            rst         = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        wait_idle();

        // EXEC_CYCLES = 15 instance
        @(posedge clk); #1 rst15 = 1'b0;
        data15 = ADD53; v15 = 1'b1;
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy15) begin
                t = cyc;
                break;
            end
        end
        chk("e15_accepted", 64'(t >= 0), 64'd1);
        @(posedge clk); #1 v15 = 1'b0;
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rv15) begin
                c = cyc;
                break;
            end
        end
        chk("e15_latency", 64'(c - t), 64'd16);
        chk("e15_data", 64'(rd15), 64'(R5));
        @(negedge clk);
        chk("e15_idle_after", 64'(busy15), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
